// File: rtl/contador_seq.sv
// Configurable up/down counter sequencer: accepts a job over a valid/ready
// handshake, then runs wrap-up, wrap-down or bounce patterns with pause and abort.
module contador_seq #(
    parameter int WIDTH = 5,
    parameter int EVW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_lo,
    input  logic [WIDTH-1:0] cfg_hi,
    input  logic [1:0]       cfg_mode,
    input  logic [EVW-1:0]   cfg_count,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] s,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0]       MODE_UP     = 2'b00;
    localparam logic [1:0]       MODE_DOWN   = 2'b01;
    localparam logic [1:0]       MODE_BOUNCE = 2'b10;
    localparam logic [1:0]       MODE_RSVD   = 2'b11;
    localparam logic [WIDTH-1:0] STEP        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [EVW-1:0]   EV_ONE      = {{(EVW-1){1'b0}}, 1'b1};
    localparam logic [EVW-1:0]   EV_ZERO     = {EVW{1'b0}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;
    logic [1:0]       mode_r;
    logic [EVW-1:0]   count_r;
    logic [EVW-1:0]   ev_r;

    logic             terminal_s;
    logic             final_s;
    logic             reject_s;
    logic [EVW-1:0]   ev_next_s;

    assign cfg_ready = (state_r == IDLE);

    // Limit detection and configuration legality
    always_comb begin
        ev_next_s  = ev_r + EV_ONE;
        terminal_s = ((dir == 1'b0) && (s == hi_r)) || ((dir == 1'b1) && (s == lo_r));
        final_s    = terminal_s && (count_r != EV_ZERO) && (ev_next_s == count_r);
        reject_s   = (cfg_lo >= cfg_hi) || (cfg_mode == MODE_RSVD);
    end

    // Sequencer state, counter datapath and registered status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            lo_r    <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            mode_r  <= MODE_UP;
            count_r <= EV_ZERO;
            ev_r    <= EV_ZERO;
            s       <= {WIDTH{1'b0}};
            dir     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cfg_valid) begin
                        if (reject_s) begin
                            err <= 1'b1;
                        end else begin
                            lo_r    <= cfg_lo;
                            hi_r    <= cfg_hi;
                            mode_r  <= cfg_mode;
                            count_r <= cfg_count;
                            ev_r    <= EV_ZERO;
                            state_r <= RUN;
                            busy    <= 1'b1;
                            s       <= (cfg_mode == MODE_DOWN) ? cfg_hi : cfg_lo;
                            dir     <= (cfg_mode == MODE_DOWN);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    // Abort outranks both the enable and a coincident final event
                    if (abort) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else if (en) begin
                        if (final_s) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (terminal_s) begin
                            ev_r <= ev_next_s;
                            case (mode_r)
                                MODE_UP:   s <= lo_r;
                                MODE_DOWN: s <= hi_r;
                                MODE_BOUNCE: begin
                                    dir <= ~dir;
                                    s   <= dir ? (lo_r + STEP) : (hi_r - STEP);
                                end
                                default:   s <= lo_r;
                            endcase
                        end else begin
                            s <= dir ? (s - STEP) : (s + STEP);
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
